load_drain_buf: RTL and testbench
=================================

# load_drain_buf

Parametrised multi-entry successor of the single-entry load/drain holding register. It provides a DEPTH-deep circular buffer of WIDTH-bit words with `load`/`drain` controls, registered head/valid state and combinational look-ahead (`_nxt`) outputs. Downstream logic sees the post-edge state one cycle early. It sits between a producer issuing `load` and a consumer issuing `drain`, and replaces hand-built next-state plus flop pairs.

## Interface
- `WIDTH`, 8: data word width, ≥1.
- `DEPTH`, 4: number of entries, ≥1. Need not be a power of two.
- `OVERWRITE`, 0: full-buffer load policy.
  - 0: drop the word.
  - 1: replace the newest entry.
- `CW`, derived: `$clog2(DEPTH+1)`, the count width. Not user-set.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: push `data` this cycle.
- `drain` in 1: pop the head this cycle.
- `data` in WIDTH: word to push.
- `q_nxt` out WIDTH: head word as it will be after the next edge (combinational).
- `valid_nxt` out 1: buffer will be non-empty after the next edge (combinational).
- `q` out WIDTH: registered head word.
- `valid` out 1: registered non-empty flag.
- `count` out CW: registered occupancy, 0..DEPTH.
- `full` out 1: `count == DEPTH` (registered).
- `ovf` out 1: sticky overflow flag.

## Operation
- State: `mem[DEPTH]`, `rd_ptr`, `wr_ptr`, `count`, `q`, `ovf`. The next-state logic is purely combinational. The flop block only copies next-state into state.
- The pointers wrap from DEPTH-1 to 0. Use explicit compare, not a power-of-two mask.
- Pop: `drain && count != 0`. A drain when empty is ignored and has no error.
- Push: `load && (count != DEPTH || pop)`. The word is written at `wr_ptr` and `wr_ptr` advances.
- Full-buffer load without drain:
  - `OVERWRITE=0`: the word is discarded and `ovf` is set.
  - `OVERWRITE=1`: the entry at `wr_ptr-1` (mod DEPTH) is replaced, pointers and count are unchanged, and `ovf` is set.
- Next count = `count + push - pop`. Simultaneous push and pop leave the count unchanged.
- `q_nxt`:
  - If the remaining entries after the pop are 0 and push is active: `data` (bypass).
  - Else if remaining > 0: `mem[rd_ptr_nxt]`. This includes the overwrite case when DEPTH=1, so the overwriting word is shown.
  - Else: holds `q`.
- `valid_nxt` = (next count != 0).
- With DEPTH=1 and OVERWRITE=1 the block matches the legacy single-entry behaviour:
  - load has data priority and sets valid.
  - drain alone clears valid.
  - load+drain on a full buffer keeps valid set, with the head equal to the new data.
- `ovf` is cleared only by `rst`.

## Timing
- Reset (async, immediate): `count=0`, `rd_ptr=wr_ptr=0`, `q=0`, `valid=0`, `full=0`, `ovf=0`. `mem` is not reset.
- While in reset, `valid_nxt=0` and `q_nxt=0`.
- `q_nxt`/`valid_nxt` settle in the same cycle as the inputs. They have zero latency and no registers.
- `q`, `valid`, `count`, `full`, `ovf` update on the `clk` rising edge, equal to the prior-cycle `_nxt` values.
- Load-to-`valid` latency is 1 cycle. Load-to-`valid_nxt` latency is 0.
- Reset asserted mid-operation discards all contents. The first edge after release behaves as if from an empty buffer.
- Inputs are sampled only at the edge. There is no handshake back-pressure; `full` is advisory.

## Structure
- Shared package/header `ldbuf_pkg`: overwrite-mode constants `LDBUF_DROP=0` and `LDBUF_OVERWRITE=1`, plus a pointer-increment-with-wrap function.
- One sub-module, `load_drain_buf_next`: the purely combinational next-state computation. Inputs are current state and controls; outputs are all `_nxt` values plus the write enable/address.
- The top level instantiates it and holds the flops and `mem`.

## Test plan
1. Reset, then WIDTH=8, DEPTH=4: load 0xA1, 0xB2, 0xC3 on consecutive edges.
   - `count` reaches 3 and `q` stays 0xA1.
   - Checking `q_nxt` before the first edge gives 0xA1.
2. Same buffer: drain three times.
   - `q` goes 0xB2, 0xC3, then holds 0xC3 with `valid=0`.
   - A fourth drain leaves `count=0` with no `ovf`.
3. Fill to 4 entries, then load 0xEE without drain:
   - `OVERWRITE=0`: `count=4`, then draining yields the original 4 words, and `ovf=1`.
   - `OVERWRITE=1`: the last drained word is 0xEE, and `ovf=1`.
4. Full buffer with load and drain together (0x55): `count` stays 4, the head advances, and 0x55 is drained last. Repeat across 5+ cycles to exercise pointer wrap with DEPTH=3.
5. DEPTH=1, OVERWRITE=1 legacy sequence:
   - load=1, data=1, then clk: `q=1`, `valid=1`.
   - data=0, then clk: `q=0`, `valid=1`.
   - load=0, drain=1: `valid_nxt=0` before the edge, then `valid=0` after.
6. Assert `rst` asynchronously mid-cycle with `count=2` and `ovf=1`: all outputs are 0 immediately. After release, load 0x7F gives `q=0x7F` and `count=1` after one edge.

Source files
------------

// File: rtl/ldbuf_pkg.sv
// Shared constants and pointer helpers for the load/drain circular buffer.
package ldbuf_pkg;

  localparam int LDBUF_DROP      = 0;
  localparam int LDBUF_OVERWRITE = 1;

  // Explicit compare keeps wrap correct for non-power-of-two depths.
  function automatic int unsigned ptr_inc(int unsigned p, int unsigned depth);
    return (p >= depth - 1) ? 32'd0 : p + 32'd1;
  endfunction

  function automatic int unsigned ptr_dec(int unsigned p, int unsigned depth);
    return (p == 32'd0) ? depth - 1 : p - 32'd1;
  endfunction

endpackage

// File: rtl/load_drain_buf_next.sv
// Combinational next-state for load_drain_buf: pointers, count, flags,
// look-ahead head word and the memory write port.
module load_drain_buf_next
  import ldbuf_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int OVERWRITE = LDBUF_DROP,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          load,
  input  logic                          drain,
  input  logic [WIDTH-1:0]              data,
  input  logic [DEPTH-1:0][WIDTH-1:0]   mem,
  input  logic [PW-1:0]                 rd_ptr,
  input  logic [PW-1:0]                 wr_ptr,
  input  logic [CW-1:0]                 count,
  input  logic [WIDTH-1:0]              q,
  input  logic                          ovf,
  output logic [PW-1:0]                 rd_ptr_nxt,
  output logic [PW-1:0]                 wr_ptr_nxt,
  output logic [CW-1:0]                 count_nxt,
  output logic [WIDTH-1:0]              q_nxt,
  output logic                          valid_nxt,
  output logic                          full_nxt,
  output logic                          ovf_nxt,
  output logic                          we,
  output logic [PW-1:0]                 waddr
);

  logic             pop, push, is_full, clobber;
  logic [CW-1:0]    remain;
  logic [PW-1:0]    newest;
  logic [WIDTH-1:0] head;

  always_comb begin
    is_full    = (count == CW'(DEPTH));
    pop        = drain && (count != '0);
    push       = load && (!is_full || pop);
    clobber    = load && is_full && !pop;
    remain     = count - CW'(pop);
    newest     = PW'(ptr_dec(32'(wr_ptr), DEPTH));

    rd_ptr_nxt = pop  ? PW'(ptr_inc(32'(rd_ptr), DEPTH)) : rd_ptr;
    wr_ptr_nxt = push ? PW'(ptr_inc(32'(wr_ptr), DEPTH)) : wr_ptr;
    count_nxt  = count + CW'(push) - CW'(pop);
    valid_nxt  = (count_nxt != '0);
    full_nxt   = (count_nxt == CW'(DEPTH));
    ovf_nxt    = ovf || clobber;

    we         = push || (clobber && (OVERWRITE == LDBUF_OVERWRITE));
    waddr      = push ? wr_ptr : newest;

    head = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_ptr_nxt == PW'(i)) head = mem[i];

    // A word written this edge at the new head (overwrite at DEPTH=1) must be forwarded.
    if (remain == '0 && push)
      q_nxt = data;
    else if (remain != '0)
      q_nxt = (we && waddr == rd_ptr_nxt) ? data : head;
    else
      q_nxt = q;
  end

endmodule

// File: rtl/load_drain_buf.sv
// DEPTH-deep circular load/drain buffer with registered head/flags and
// zero-latency look-ahead (_nxt) outputs.
module load_drain_buf
  import ldbuf_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int OVERWRITE = LDBUF_DROP,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q_nxt,
  output logic             valid_nxt,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n, waddr;
  logic [CW-1:0]               count_n;
  logic [WIDTH-1:0]            q_n;
  logic                        valid_n, full_n, ovf_n, we;

  load_drain_buf_next #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(OVERWRITE)
  ) u_next (
    .load       (load),
    .drain      (drain),
    .data       (data),
    .mem        (mem),
    .rd_ptr     (rd_ptr),
    .wr_ptr     (wr_ptr),
    .count      (count),
    .q          (q),
    .ovf        (ovf),
    .rd_ptr_nxt (rd_ptr_n),
    .wr_ptr_nxt (wr_ptr_n),
    .count_nxt  (count_n),
    .q_nxt      (q_n),
    .valid_nxt  (valid_n),
    .full_nxt   (full_n),
    .ovf_nxt    (ovf_n),
    .we         (we),
    .waddr      (waddr)
  );

  // Look-ahead is forced quiet while reset holds the state.
  assign q_nxt     = rst ? '0 : q_n;
  assign valid_nxt = !rst && valid_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q      <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
      q      <= q_n;
      valid  <= valid_n;
      full   <= full_n;
      ovf    <= ovf_n;
    end
  end

  // Storage is not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (we && waddr == PW'(i)) mem[i] <= data;
  end

endmodule

// File: tb/tb_load_drain_buf.sv
// Four load_drain_buf configurations driven by one stimulus stream, each
// checked against a list-based reference model.
module tb_load_drain_buf;
  import ldbuf_pkg::*;

  localparam int NI = 4;
  localparam int DEP [NI] = '{4, 4, 3, 1};
  localparam int OWM [NI] = '{0, 1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load = 1'b0;
  logic drain = 1'b0;
  logic [7:0] data = 8'h00;

  logic [NI-1:0][7:0] q_nxt, q;
  logic [NI-1:0]      valid_nxt, valid, full, ovf;
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [0:0] cnt3;

  always #5 clk = ~clk;

  load_drain_buf #(.WIDTH(8), .DEPTH(4), .OVERWRITE(LDBUF_DROP)) u0 (
    .clk(clk), .rst(rst), .load(load), .drain(drain), .data(data),
    .q_nxt(q_nxt[0]), .valid_nxt(valid_nxt[0]), .q(q[0]), .valid(valid[0]),
    .count(cnt0), .full(full[0]), .ovf(ovf[0]));
  load_drain_buf #(.WIDTH(8), .DEPTH(4), .OVERWRITE(LDBUF_OVERWRITE)) u1 (
    .clk(clk), .rst(rst), .load(load), .drain(drain), .data(data),
    .q_nxt(q_nxt[1]), .valid_nxt(valid_nxt[1]), .q(q[1]), .valid(valid[1]),
    .count(cnt1), .full(full[1]), .ovf(ovf[1]));
  load_drain_buf #(.WIDTH(8), .DEPTH(3), .OVERWRITE(LDBUF_DROP)) u2 (
    .clk(clk), .rst(rst), .load(load), .drain(drain), .data(data),
    .q_nxt(q_nxt[2]), .valid_nxt(valid_nxt[2]), .q(q[2]), .valid(valid[2]),
    .count(cnt2), .full(full[2]), .ovf(ovf[2]));
  load_drain_buf #(.WIDTH(8), .DEPTH(1), .OVERWRITE(LDBUF_OVERWRITE)) u3 (
    .clk(clk), .rst(rst), .load(load), .drain(drain), .data(data),
    .q_nxt(q_nxt[3]), .valid_nxt(valid_nxt[3]), .q(q[3]), .valid(valid[3]),
    .count(cnt3), .full(full[3]), .ovf(ovf[3]));

  // Model: ordered list of stored words (index 0 = head), shown head, sticky ovf.
  logic [7:0] mlist [NI][4];
  int         msize [NI];
  logic [7:0] mq    [NI];
  bit         movf  [NI];
  logic [7:0] nlist [NI][4];
  int         nsize [NI];
  logic [7:0] nq    [NI];
  bit         novf  [NI];

  int vectors = 0;
  int miscompares = 0;

  function automatic int cnt_of(int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      msize[i] = 0;
      mq[i]    = 8'h00;
      movf[i]  = 1'b0;
    end
  endtask

  task automatic predict(bit l, bit d, logic [7:0] v);
    for (int i = 0; i < NI; i++) begin
      bit pop;
      pop      = d && (msize[i] > 0);
      nsize[i] = msize[i];
      novf[i]  = movf[i];
      for (int j = 0; j < 4; j++) nlist[i][j] = mlist[i][j];
      if (pop) begin
        for (int j = 0; j < 3; j++) nlist[i][j] = nlist[i][j+1];
        nsize[i]--;
      end
      if (l) begin
        if (msize[i] < DEP[i] || pop) begin
          nlist[i][nsize[i]] = v;
          nsize[i]++;
        end else begin
          novf[i] = 1'b1;
          if (OWM[i] == 1) nlist[i][nsize[i]-1] = v;
        end
      end
      nq[i] = (nsize[i] > 0) ? nlist[i][0] : mq[i];
    end
  endtask

  task automatic commit();
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 4; j++) mlist[i][j] = nlist[i][j];
      msize[i] = nsize[i];
      mq[i]    = nq[i];
      movf[i]  = novf[i];
    end
  endtask

  task automatic check_regs(string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_q"},     i, 32'(q[i]),     32'(mq[i]));
      chk({tag, "_valid"}, i, 32'(valid[i]), 32'(msize[i] > 0));
      chk({tag, "_count"}, i, 32'(cnt_of(i)), 32'(msize[i]));
      chk({tag, "_full"},  i, 32'(full[i]),  32'(msize[i] == DEP[i]));
      chk({tag, "_ovf"},   i, 32'(ovf[i]),   32'(movf[i]));
    end
  endtask

  task automatic step(bit l, bit d, logic [7:0] v);
    @(negedge clk);
    load = l; drain = d; data = v;
    predict(l, d, v);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("q_nxt",     i, 32'(q_nxt[i]),     32'(nq[i]));
      chk("valid_nxt", i, 32'(valid_nxt[i]), 32'(nsize[i] > 0));
    end
    @(posedge clk);
    commit();
    #1 check_regs("reg");
  endtask

  // Reset is applied with load active to show the look-ahead stays quiet.
  task automatic reset_check(string tag);
    rst = 1'b1; load = 1'b1; drain = 1'b0; data = 8'h5A;
    model_reset();
    #1;
    check_regs(tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_q_nxt"},     i, 32'(q_nxt[i]),     32'd0);
      chk({tag, "_valid_nxt"}, i, 32'(valid_nxt[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    reset_check("rst0");

    // Three consecutive loads; head stays the first word.
    step(1, 0, 8'hA1);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hC3);
    chk("tp1_count", 0, 32'(cnt0), 32'd3);
    chk("tp1_q",     0, 32'(q[0]), 32'hA1);

    // Drain out, plus one drain on empty.
    repeat (4) step(0, 1, 8'h00);
    chk("tp2_q",     0, 32'(q[0]),     32'hC3);
    chk("tp2_valid", 0, 32'(valid[0]), 32'd0);
    chk("tp2_ovf",   0, 32'(ovf[0]),   32'd0);

    // Fill, then load into a full buffer.
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    step(1, 0, 8'hEE);
    chk("tp3_count", 0, 32'(cnt0), 32'd4);
    repeat (4) step(0, 1, 8'h00);
    chk("tp3_drop_last", 0, 32'(q[0]), 32'h44);
    chk("tp3_ovw_last",  1, 32'(q[1]), 32'hEE);
    chk("tp3_ovf",       0, 32'(ovf[0]), 32'd1);
    chk("tp3_ovf",       1, 32'(ovf[1]), 32'd1);
    step(0, 1, 8'h00);

    // Full buffer with simultaneous load and drain, across pointer wrap.
    for (int k = 1; k <= 4; k++) step(1, 0, 8'(8'h10 * k));
    for (int k = 0; k < 6; k++) step(1, 1, 8'(8'h50 + k));
    chk("tp4_count", 0, 32'(cnt0), 32'd4);
    repeat (4) step(0, 1, 8'h00);
    chk("tp4_last", 0, 32'(q[0]), 32'h55);
    chk("tp4_last", 2, 32'(q[2]), 32'h55);

    // Legacy single-entry sequence.
    step(1, 0, 8'h01);
    chk("tp5_q1", 3, 32'(q[3]), 32'h01);
    chk("tp5_v1", 3, 32'(valid[3]), 32'd1);
    step(1, 0, 8'h00);
    chk("tp5_q0", 3, 32'(q[3]), 32'h00);
    chk("tp5_v0", 3, 32'(valid[3]), 32'd1);
    step(0, 1, 8'h00);
    chk("tp5_vclr", 3, 32'(valid[3]), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Mid-cycle asynchronous reset with live contents and ovf set.
    @(negedge clk);
    reset_check("rst1");
    for (int k = 0; k < 5; k++) step(1, 0, 8'(8'h61 + k));
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    chk("tp6_pre_count", 0, 32'(cnt0), 32'd2);
    chk("tp6_pre_ovf",   0, 32'(ovf[0]), 32'd1);
    #3;
    reset_check("rst2");
    step(1, 0, 8'h7F);
    chk("tp6_q",     0, 32'(q[0]), 32'h7F);
    chk("tp6_count", 0, 32'(cnt0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
